// File: rtl/frodo_io_scheduler_pkg.sv
// Shared definitions for the FrodoKEM command / I/O-phase scheduler:
// command codes, parameter-set encoding, FSM states and the per-segment
// word counts that make up each command's phase table.
package frodo_io_scheduler_pkg;

  localparam int MainCMD_SIZE = 4;
  localparam int PHASE_W      = 4;
  localparam int CNT_W        = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  // Command codes; every other value is reported as an unknown command.
  localparam logic [MainCMD_SIZE-1:0] MainCMD_setParam640  = 4'd1;
  localparam logic [MainCMD_SIZE-1:0] MainCMD_setParam976  = 4'd2;
  localparam logic [MainCMD_SIZE-1:0] MainCMD_setParam1344 = 4'd3;
  localparam logic [MainCMD_SIZE-1:0] MainCMD_setupTest    = 4'd4;
  localparam logic [MainCMD_SIZE-1:0] MainCMD_keygen       = 4'd5;
  localparam logic [MainCMD_SIZE-1:0] MainCMD_encaps       = 4'd6;
  localparam logic [MainCMD_SIZE-1:0] MainCMD_decaps       = 4'd7;

  // Active parameter set as seen on the param output.
  typedef enum logic [1:0] {
    SET_640  = 2'd0,
    SET_976  = 2'd1,
    SET_1344 = 2'd2
  } param_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Phase direction bit.
  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  // Named data segments; each phase of each command moves one segment.
  typedef enum logic [3:0] {
    SEG_SEEDSE, SEG_S, SEG_ZEROS, SEG_Z, SEG_BIG_S, SEG_SEEDA,
    SEG_B, SEG_PKH, SEG_C1, SEG_C2, SEG_SALT, SEG_SS
  } seg_e;

  function automatic logic cmd_is_set_param(input logic [MainCMD_SIZE-1:0] c);
    return (c == MainCMD_setParam640) || (c == MainCMD_setParam976) ||
           (c == MainCMD_setParam1344);
  endfunction

  function automatic logic cmd_is_known(input logic [MainCMD_SIZE-1:0] c);
    return cmd_is_set_param(c) || (c == MainCMD_setupTest) || (c == MainCMD_keygen) ||
           (c == MainCMD_encaps) || (c == MainCMD_decaps);
  endfunction

  function automatic logic [1:0] set_of_cmd(input logic [MainCMD_SIZE-1:0] c);
    logic [1:0] s;
    s = SET_640;
    if (c == MainCMD_setParam976)  s = SET_976;
    if (c == MainCMD_setParam1344) s = SET_1344;
    return s;
  endfunction

  function automatic cnt_t by_set(input logic [1:0] set, input cnt_t n640,
                                  input cnt_t n976, input cnt_t n1344);
    return (set == SET_976) ? n976 : (set == SET_1344) ? n1344 : n640;
  endfunction

  // Word count minus one of a segment under a given parameter set.
  function automatic cnt_t seg_words_m1(input seg_e seg, input logic [1:0] set);
    cnt_t n;
    case (seg)
      SEG_SEEDSE, SEG_ZEROS, SEG_SALT: n = by_set(set, 12'd4, 12'd6, 12'd8);
      SEG_S, SEG_PKH, SEG_SS:          n = by_set(set, 12'd2, 12'd3, 12'd4);
      SEG_Z, SEG_SEEDA:                n = 12'd2;
      SEG_BIG_S:                       n = by_set(set, 12'd1280, 12'd1952, 12'd2688);
      SEG_B, SEG_C1:                   n = by_set(set, 12'd1200, 12'd1952, 12'd2688);
      SEG_C2:                          n = by_set(set, 12'd15, 12'd16, 12'd16);
      default:                         n = 12'd1;
    endcase
    return n - 12'd1;
  endfunction

endpackage

// File: rtl/frodo_phase_rom.sv
// Combinational phase table: (command, parameter set, phase index) ->
// direction, last-phase flag and word count minus one for that phase.
module frodo_phase_rom
  import frodo_io_scheduler_pkg::*;
(
  input  logic [MainCMD_SIZE-1:0] cmd,
  input  logic [1:0]              set,
  input  logic [PHASE_W-1:0]      phase,
  output logic                    dir,
  output logic                    last_phase,
  output cnt_t                    words_m1
);

  seg_e seg;

  // Map the phase index of each command onto its segment and direction.
  always_comb begin
    seg        = SEG_SS;
    dir        = DIR_IN;
    last_phase = 1'b1;
    case (cmd)
      MainCMD_setupTest: begin
        last_phase = (phase == 4'd3);
        case (phase)
          4'd0:    seg = SEG_SEEDSE;
          4'd1:    seg = SEG_S;
          4'd2:    seg = SEG_ZEROS;
          default: seg = SEG_Z;
        endcase
      end
      MainCMD_keygen: begin
        dir        = DIR_OUT;
        last_phase = (phase == 4'd4);
        case (phase)
          4'd0:    seg = SEG_S;
          4'd1:    seg = SEG_BIG_S;
          4'd2:    seg = SEG_SEEDA;
          4'd3:    seg = SEG_B;
          default: seg = SEG_PKH;
        endcase
      end
      MainCMD_encaps: begin
        dir        = (phase >= 4'd2) ? DIR_OUT : DIR_IN;
        last_phase = (phase == 4'd5);
        case (phase)
          4'd0:    seg = SEG_SEEDA;
          4'd1:    seg = SEG_B;
          4'd2:    seg = SEG_C1;
          4'd3:    seg = SEG_C2;
          4'd4:    seg = SEG_SALT;
          default: seg = SEG_SS;
        endcase
      end
      MainCMD_decaps: begin
        dir        = (phase == 4'd8) ? DIR_OUT : DIR_IN;
        last_phase = (phase == 4'd8);
        case (phase)
          4'd0:    seg = SEG_BIG_S;
          4'd1:    seg = SEG_C1;
          4'd2:    seg = SEG_C2;
          4'd3:    seg = SEG_SALT;
          4'd4:    seg = SEG_PKH;
          4'd5:    seg = SEG_B;
          4'd6:    seg = SEG_SEEDA;
          4'd7:    seg = SEG_S;
          default: seg = SEG_SS;
        endcase
      end
      default: ;
    endcase
    words_m1 = seg_words_m1(seg, set);
  end

endmodule

// File: rtl/frodo_io_scheduler.sv
// Command and I/O-phase scheduler in front of the FrodoKEM main core.
// Handshake rule for every stream (cmd, in, out, core_*): *_isReady is the
// sender's valid, *_canReceive is the receiver's ready, and a word moves on
// the rising clk edge where both are high. In XFER the active direction is a
// pure combinational pass-through, the inactive one is held at 0.
module frodo_io_scheduler
  import frodo_io_scheduler_pkg::*;
#(
  parameter int CMD_W  = MainCMD_SIZE,
  parameter int WORD_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               cmd_isReady,
  output logic               cmd_canReceive,
  input  logic [WORD_W-1:0]  in,
  input  logic               in_isReady,
  output logic               in_canReceive,
  output logic [WORD_W-1:0]  out,
  output logic               out_isReady,
  input  logic               out_canReceive,
  output logic [CMD_W-1:0]   core_cmd,
  output logic               core_cmd_isReady,
  input  logic               core_cmd_canReceive,
  output logic [WORD_W-1:0]  core_in,
  output logic               core_in_isReady,
  input  logic               core_in_canReceive,
  input  logic [WORD_W-1:0]  core_out,
  input  logic               core_out_isReady,
  output logic               core_out_canReceive,
  output logic [1:0]         param,
  output logic [PHASE_W-1:0] phase,
  output logic               done,
  output logic               badCmd,
  output logic [1:0]         dbg_state
);

  sched_state_e       state_q, state_d;
  logic [1:0]         param_q;
  logic [CMD_W-1:0]   cmd_q;
  logic [PHASE_W-1:0] phase_q;
  cnt_t               cnt_q;
  logic               bad_q;
  logic               accept, fire;
  logic               cmd_known, cmd_is_set;
  logic [1:0]         cmd_set;
  logic               rom_dir, rom_last;
  cnt_t               rom_words_m1;

  assign cmd_known  = cmd_is_known(MainCMD_SIZE'(cmd));
  assign cmd_is_set = cmd_is_set_param(MainCMD_SIZE'(cmd));
  assign cmd_set    = set_of_cmd(MainCMD_SIZE'(cmd));

  frodo_phase_rom u_rom (
    .cmd        (MainCMD_SIZE'(cmd_q)),
    .set        (param_q),
    .phase      (phase_q),
    .dir        (rom_dir),
    .last_phase (rom_last),
    .words_m1   (rom_words_m1)
  );

  // Next state plus all handshake gating; everything idles at 0 by default.
  always_comb begin
    state_d             = state_q;
    accept              = 1'b0;
    fire                = 1'b0;
    done                = 1'b0;
    cmd_canReceive      = 1'b0;
    core_cmd            = '0;
    core_cmd_isReady    = 1'b0;
    core_in             = '0;
    core_in_isReady     = 1'b0;
    in_canReceive       = 1'b0;
    out                 = '0;
    out_isReady         = 1'b0;
    core_out_canReceive = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while rst is asserted so every handshake drops at once.
        cmd_canReceive = ~rst;
        if (cmd_isReady) begin
          accept = 1'b1;
          if (cmd_known) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_cmd         = cmd_q;
        core_cmd_isReady = 1'b1;
        if (core_cmd_canReceive)
          state_d = cmd_is_set_param(MainCMD_SIZE'(cmd_q)) ? ST_IDLE : ST_XFER;
      end
      ST_XFER: begin
        if (rom_dir == DIR_IN) begin
          core_in         = in;
          core_in_isReady = in_isReady;
          in_canReceive   = core_in_canReceive;
          fire            = in_isReady & core_in_canReceive;
        end else begin
          out                 = core_out;
          out_isReady         = core_out_isReady;
          core_out_canReceive = out_canReceive;
          fire                = core_out_isReady & out_canReceive;
        end
        if (fire && (cnt_q == rom_words_m1) && rom_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, accepted command, active parameter set and badCmd pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      param_q <= SET_640;
      cmd_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bad_q   <= accept & ~cmd_known;
      if (accept && cmd_known) begin
        cmd_q <= cmd;
        if (cmd_is_set) param_q <= cmd_set;
      end
    end
  end

  // Word counter and phase index; both restart when a command is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == ST_ISSUE) begin
      phase_q <= '0;
      cnt_q   <= '0;
    end else if (fire) begin
      if (cnt_q == rom_words_m1) begin
        cnt_q   <= '0;
        phase_q <= rom_last ? '0 : phase_q + 4'd1;
      end else begin
        cnt_q <= cnt_q + 12'd1;
      end
    end
  end

  assign param     = param_q;
  assign phase     = (state_q == ST_XFER) ? phase_q : '0;
  assign badCmd    = bad_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_frodo_io_scheduler.sv
// Bench for frodo_io_scheduler: a command table for the single-cycle decode
// cases, then complete commands with random handshakes checked against a
// phase-list model built from the FrodoKEM phase tables.
module tb_frodo_io_scheduler;
  import frodo_io_scheduler_pkg::*;

  localparam int WORD_W = 64;
  localparam int XFER_BUDGET = 30000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]        cmd;
  logic              cmd_isReady, cmd_canReceive;
  logic [WORD_W-1:0] in, out, core_in, core_out;
  logic              in_isReady, in_canReceive, out_isReady, out_canReceive;
  logic [3:0]        core_cmd;
  logic              core_cmd_isReady, core_cmd_canReceive;
  logic              core_in_isReady, core_in_canReceive;
  logic              core_out_isReady, core_out_canReceive;
  logic [1:0]        param;
  logic [3:0]        phase;
  logic              done, badCmd;
  logic [1:0]        dbg_state;

  frodo_io_scheduler #(.CMD_W(MainCMD_SIZE), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_isReady(cmd_isReady), .cmd_canReceive(cmd_canReceive),
    .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
    .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive),
    .core_cmd(core_cmd), .core_cmd_isReady(core_cmd_isReady),
    .core_cmd_canReceive(core_cmd_canReceive),
    .core_in(core_in), .core_in_isReady(core_in_isReady),
    .core_in_canReceive(core_in_canReceive),
    .core_out(core_out), .core_out_isReady(core_out_isReady),
    .core_out_canReceive(core_out_canReceive),
    .param(param), .phase(phase), .done(done), .badCmd(badCmd),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] out_seq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // ---------------- reference model: phase lists ----------------
  // dir 0 = external in -> core, dir 1 = core -> external out.
  int plan_dir[$];
  int plan_cnt[$];

  function automatic int wc(input string nm, input int s);
    if (nm == "seedSE" || nm == "zeros" || nm == "salt") return 4 + 2 * s;
    if (nm == "s" || nm == "pkh" || nm == "ss") return 2 + s;
    if (nm == "z" || nm == "seedA") return 2;
    if (nm == "S") return (s == 0) ? 1280 : (s == 1) ? 1952 : 2688;
    if (nm == "b" || nm == "c1") return (s == 0) ? 1200 : (s == 1) ? 1952 : 2688;
    if (nm == "c2") return (s == 0) ? 15 : 16;
    return 0;
  endfunction

  task automatic add_ph(input int dir, input string nm, input int s);
    plan_dir.push_back(dir);
    plan_cnt.push_back(wc(nm, s));
  endtask

  task automatic build_plan(input logic [3:0] code, input int s);
    plan_dir.delete();
    plan_cnt.delete();
    if (code == MainCMD_setupTest) begin
      add_ph(0, "seedSE", s); add_ph(0, "s", s); add_ph(0, "zeros", s); add_ph(0, "z", s);
    end else if (code == MainCMD_keygen) begin
      add_ph(1, "s", s); add_ph(1, "S", s); add_ph(1, "seedA", s);
      add_ph(1, "b", s); add_ph(1, "pkh", s);
    end else if (code == MainCMD_encaps) begin
      add_ph(0, "seedA", s); add_ph(0, "b", s);
      add_ph(1, "c1", s); add_ph(1, "c2", s); add_ph(1, "salt", s); add_ph(1, "ss", s);
    end else if (code == MainCMD_decaps) begin
      add_ph(0, "S", s); add_ph(0, "c1", s); add_ph(0, "c2", s); add_ph(0, "salt", s);
      add_ph(0, "pkh", s); add_ph(0, "b", s); add_ph(0, "seedA", s); add_ph(0, "s", s);
      add_ph(1, "ss", s);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [3:0] code);
    @(negedge clk);
    cmd = code;
    cmd_isReady = 1'b1;
    @(posedge clk);
    #1;
    cmd_isReady = 1'b0;
    cmd = '0;
  endtask

  // Core holds off the command for `hold` cycles, then takes it.
  task automatic issue_cmd(input logic [3:0] code, input int hold);
    core_cmd_canReceive = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      #1;
      chk("core_cmd_isReady", 64'(core_cmd_isReady), 64'd1);
      chk("core_cmd", 64'(core_cmd), 64'(code));
      if (i == hold) core_cmd_canReceive = 1'b1;
    end
    @(posedge clk);
    #1;
    core_cmd_canReceive = 1'b0;
  endtask

  task automatic set_param(input logic [3:0] code, input logic [1:0] expv);
    send_cmd(code);
    issue_cmd(code, $urandom_range(1));
    @(negedge clk);
    #1;
    chk("setparam_param", 64'(param), 64'(expv));
    chk("setparam_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
    chk("setparam_no_done", 64'(done), 64'd0);
  endtask

  task automatic clear_handshakes();
    in_isReady = 1'b0; core_in_canReceive = 1'b0;
    core_out_isReady = 1'b0; out_canReceive = 1'b0;
    cmd_isReady = 1'b0; cmd = '0;
  endtask

  // Walk the model's phase list with random handshakes; optionally keep a
  // setParam1344 request pending, or assert rst after abort_at words.
  task automatic run_xfer(input int pct, input logic busy, input int abort_at,
                          input logic [1:0] exp_param);
    int ph = 0, cnt = 0, cyc = 0, moved = 0;
    logic fire;
    while (ph < plan_dir.size()) begin
      @(negedge clk);
      in = {$urandom, $urandom};
      in_isReady = rnd(pct);
      core_in_canReceive = rnd(pct);
      core_out = out_seq;
      core_out_isReady = rnd(pct);
      out_canReceive = rnd(pct);
      if (busy) begin
        cmd = MainCMD_setParam1344;
        cmd_isReady = rnd(50);
      end
      #1;
      chk("phase", 64'(phase), 64'(ph));
      chk("done_early", 64'(done), 64'd0);
      chk("cmd_canReceive_busy", 64'(cmd_canReceive), 64'd0);
      chk("param_held", 64'(param), 64'(exp_param));
      if (plan_dir[ph] == 0) begin
        chk("core_in_isReady", 64'(core_in_isReady), 64'(in_isReady));
        chk("in_canReceive", 64'(in_canReceive), 64'(core_in_canReceive));
        chk("out_isReady_idle", 64'(out_isReady), 64'd0);
        chk("core_out_canReceive_idle", 64'(core_out_canReceive), 64'd0);
      end else begin
        chk("out_isReady", 64'(out_isReady), 64'(core_out_isReady));
        chk("core_out_canReceive", 64'(core_out_canReceive), 64'(out_canReceive));
        chk("core_in_isReady_idle", 64'(core_in_isReady), 64'd0);
        chk("in_canReceive_idle", 64'(in_canReceive), 64'd0);
      end
      if (abort_at >= 0 && moved == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_core_in_isReady", 64'(core_in_isReady), 64'd0);
        chk("abort_in_canReceive", 64'(in_canReceive), 64'd0);
        chk("abort_out_isReady", 64'(out_isReady), 64'd0);
        chk("abort_core_out_canReceive", 64'(core_out_canReceive), 64'd0);
        chk("abort_core_cmd_isReady", 64'(core_cmd_isReady), 64'd0);
        chk("abort_cmd_canReceive", 64'(cmd_canReceive), 64'd0);
        chk("abort_param", 64'(param), 64'd0);
        chk("abort_phase", 64'(phase), 64'd0);
        chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        clear_handshakes();
        exp_q.delete();
        #1;
        chk("abort_cmd_canReceive_after", 64'(cmd_canReceive), 64'd1);
        return;
      end
      if (plan_dir[ph] == 0) begin
        fire = in_isReady && core_in_canReceive;
        if (fire) begin
          exp_q.push_back(in);
          chk("core_in_data", core_in, exp_q.pop_front());
        end
      end else begin
        fire = core_out_isReady && out_canReceive;
        if (fire) begin
          exp_q.push_back(out_seq);
          chk("out_data", out, exp_q.pop_front());
          out_seq++;
        end
      end
      if (fire) begin
        moved++;
        cnt++;
        if (cnt == plan_cnt[ph]) begin
          ph++;
          cnt = 0;
        end
      end
      cyc++;
      if (cyc > XFER_BUDGET) begin
        n_checks++;
        n_fail++;
        $display("FAIL xfer_timeout: still in phase %0d after %0d cycles", ph, cyc);
        break;
      end
    end
    @(posedge clk);
    #1;
    clear_handshakes();
    @(negedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("state_done", 64'(dbg_state), 64'(ST_DONE));
    chk("phase_after_xfer", 64'(phase), 64'd0);
    @(negedge clk);
    #1;
    chk("done_single", 64'(done), 64'd0);
    chk("state_idle_after_done", 64'(dbg_state), 64'(ST_IDLE));
    chk("cmd_canReceive_after_done", 64'(cmd_canReceive), 64'd1);
  endtask

  task automatic run_cmd(input logic [3:0] code, input logic [1:0] set, input int pct,
                         input logic busy, input int abort_at);
    build_plan(code, int'(set));
    send_cmd(code);
    issue_cmd(code, $urandom_range(2));
    run_xfer(pct, busy, abort_at, set);
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [3:0] code;
    logic [1:0] exp_param;
    logic       exp_bad;
  } cmd_vec_t;

  cmd_vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{MainCMD_setParam976,  2'd1, 1'b0};
    vecs[1] = '{4'd0,                 2'd1, 1'b1};
    vecs[2] = '{MainCMD_setParam1344, 2'd2, 1'b0};
    vecs[3] = '{4'd15,                2'd2, 1'b1};
    vecs[4] = '{4'd8,                 2'd2, 1'b1};
    vecs[5] = '{MainCMD_setParam640,  2'd0, 1'b0};
    vecs[6] = '{4'd9,                 2'd0, 1'b1};

    rst = 1'b1;
    cmd = '0; cmd_isReady = 1'b0; in = '0; in_isReady = 1'b0; out_canReceive = 1'b0;
    core_cmd_canReceive = 1'b0; core_in_canReceive = 1'b0;
    core_out = '0; core_out_isReady = 1'b0;
    out_seq = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
    chk("rst_in_canReceive", 64'(in_canReceive), 64'd0);
    chk("rst_out_isReady", 64'(out_isReady), 64'd0);
    chk("rst_core_cmd_isReady", 64'(core_cmd_isReady), 64'd0);
    chk("rst_core_in_isReady", 64'(core_in_isReady), 64'd0);
    chk("rst_core_out_canReceive", 64'(core_out_canReceive), 64'd0);
    chk("rst_param", 64'(param), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_badCmd", 64'(badCmd), 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_core_in", core_in, 64'd0);
    chk("rst_core_cmd", 64'(core_cmd), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // setParam and unknown codes from IDLE, core always ready for commands.
    core_cmd_canReceive = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_cmd(vecs[i].code);
      @(negedge clk);
      #1;
      chk("tbl_badCmd", 64'(badCmd), 64'(vecs[i].exp_bad));
      chk("tbl_param", 64'(param), 64'(vecs[i].exp_param));
      chk("tbl_state", 64'(dbg_state), vecs[i].exp_bad ? 64'(ST_IDLE) : 64'(ST_ISSUE));
      chk("tbl_core_cmd_isReady", 64'(core_cmd_isReady), 64'(!vecs[i].exp_bad));
      @(negedge clk);
      #1;
      chk("tbl_badCmd_pulse", 64'(badCmd), 64'd0);
      chk("tbl_idle", 64'(dbg_state), 64'(ST_IDLE));
      chk("tbl_cmd_canReceive", 64'(cmd_canReceive), 64'd1);
      chk("tbl_no_done", 64'(done), 64'd0);
    end
    core_cmd_canReceive = 1'b0;

    // setupTest at 640, words back to back, then a 13th word is refused.
    run_cmd(MainCMD_setupTest, 2'd0, 100, 1'b0, -1);
    @(negedge clk);
    in_isReady = 1'b1;
    core_in_canReceive = 1'b1;
    #1;
    chk("word13_in_canReceive", 64'(in_canReceive), 64'd0);
    chk("word13_core_in_isReady", 64'(core_in_isReady), 64'd0);
    clear_handshakes();

    // keygen at 1344 with a randomly stalling sink.
    set_param(MainCMD_setParam1344, 2'd2);
    run_cmd(MainCMD_keygen, 2'd2, 80, 1'b0, -1);

    // encaps at 640 with a setParam request pending the whole time.
    set_param(MainCMD_setParam640, 2'd0);
    run_cmd(MainCMD_encaps, 2'd0, 75, 1'b1, -1);

    // decaps at 976 aborted by rst during phase S, then a fresh decaps at 640.
    set_param(MainCMD_setParam976, 2'd1);
    run_cmd(MainCMD_decaps, 2'd1, 100, 1'b0, 700);
    run_cmd(MainCMD_decaps, 2'd0, 85, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frodo_io_scheduler.md
# frodo_io_scheduler

Command and I/O-phase scheduler sitting between the external `cmd`/`in`/`out` streaming ports and the FrodoKEM `main` core. It accepts one command at a time, holds the active parameter set (640/976/1344), forwards the command to the core, then walks a fixed per-command table of I/O phases. Each phase has a direction and an exact 64-bit word count. It gates the core's input and output handshakes so that only legal words move in the legal order, and it signals completion.

## Interface
- `CMD_W`, default `MainCMD_SIZE`: command width.
- `WORD_W`, default 64: stream word width.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous reset, active-high.
- `cmd`  in  CMD_W  external command.
- `cmd_isReady`  in  1  external command valid.
- `cmd_canReceive`  out  1  scheduler idle; high when the scheduler can accept a command.
- `in`  in  WORD_W  external input word.
- `in_isReady`  in  1  external input valid.
- `in_canReceive`  out  1  input accepted this cycle.
- `out`  out  WORD_W  external output word.
- `out_isReady`  out  1  output valid.
- `out_canReceive`  in  1  external sink ready.
- `core_cmd`, `core_cmd_isReady` (out), `core_cmd_canReceive` (in): command forwarded to the core.
- `core_in`, `core_in_isReady` (out), `core_in_canReceive` (in): core input stream.
- `core_out`, `core_out_isReady` (in), `core_out_canReceive` (out): core output stream.
- `param`  out  2  active set: 0=640, 1=976, 2=1344.
- `phase`  out  4  current phase index (0 outside XFER).
- `done`  out  1  one-cycle pulse after the last word of a command.
- `badCmd`  out  1  one-cycle pulse when an unknown code is accepted.

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- **IDLE**
  - `cmd_canReceive`=1.
  - Accept when `cmd_isReady`.
  - setParam*: update `param` and go to ISSUE.
  - setupTest, keygen, encaps, decaps: latch the command and go to ISSUE.
  - Unknown code: pulse `badCmd` and stay in IDLE.
- **ISSUE**
  - Drive `core_cmd`=latched command with `core_cmd_isReady`=1 until `core_cmd_canReceive`.
  - setParam* then goes to IDLE with no `done` pulse.
  - All other commands go to XFER with phase 0 and word count 0.
- **XFER**
  - Input phase:
    - `core_in`=`in`.
    - `core_in_isReady`=`in_isReady`.
    - `in_canReceive`=`core_in_canReceive`.
  - Output phase:
    - `out`=`core_out`.
    - `out_isReady`=`core_out_isReady`.
    - `core_out_canReceive`=`out_canReceive`.
  - Handshake signals of the inactive direction are forced to 0.
  - A word transfers when both sides of the active direction are high; each transfer increments the word counter.
  - On the last word of a phase: counter returns to 0 and `phase` increments.
  - On the last word of the last phase: go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Phase tables (direction and word count per set 640/976/1344):
  - setupTest (all inputs): seedSE 4/6/8, s 2/3/4, zeros 4/6/8, z 2/2/2.
  - keygen (all outputs): s 2/3/4, S 1280/1952/2688, seedA 2/2/2, b 1200/1952/2688, pkh 2/3/4.
  - encaps:
    - inputs: seedA 2, b 1200/1952/2688.
    - outputs: c1 1200/1952/2688, c2 15/16/16, salt 4/6/8, ss 2/3/4.
  - decaps:
    - inputs: S, c1, c2, salt, pkh, b, seedA, s, with counts as above.
    - output: ss 2/3/4.
- Word counter is 12 bits; the maximum count is 2688. Comparison is against count−1, so no wrap is possible.
- `param` is not changeable outside IDLE. A setParam while busy is held off because `cmd_canReceive`=0.

## Timing
- Reset values:
  - All `*_isReady` and `*_canReceive` outputs are 0, except `cmd_canReceive`=1 after reset is released.
  - `param`=0, `phase`=0, `done`=0, `badCmd`=0, state=IDLE.
  - `out`, `core_in` and `core_cmd` are 0.
- `core_cmd_isReady` rises the cycle after acceptance.
- Stream paths are combinational pass-through with zero added latency, so one word per cycle is sustained across phase boundaries. The first word of phase n+1 can transfer in the cycle after the last word of phase n.
- `done` rises the cycle after the final word's transfer edge.
- Reset asserted mid-operation aborts immediately:
  - State and counters are cleared.
  - `param` returns to 640.
  - The core is not notified; the core has its own `rst`.

## Structure
- Shared header holds:
  - `MainCMD_*` codes.
  - Param-set encoding.
  - The phase-table constants (direction bit and word count per command, phase and set).
- One sub-module, `frodo_phase_rom`: combinational lookup from (command, set, phase) to {direction, lastPhase, wordCount−1}.
- The FSM, counter and handshake gating live in the top.

## Test plan
- Reset, then setParam976 → `param`=1. No `done` pulse. `cmd_canReceive` is high 2 cycles after acceptance.
- setupTest at 640 with 12 input words sent back-to-back → `phase` reads 0,1,2,3. `done` pulses once, the cycle after word 12. A 13th word sees `in_canReceive`=0.
- keygen at 1344 → output counts are exactly 4, 2688, 2, 2688, 4. `in_canReceive` stays 0 throughout. `out_canReceive` toggled randomly causes no lost or duplicated words.
- encaps at 640 → after 1202 input words, the direction switches. During output phases, `in_isReady`=1 is ignored. c2 is exactly 15 words.
- Unknown code → `badCmd` pulse and state stays IDLE. A command asserted while in XFER is not accepted.
- `rst` pulsed in the middle of decaps phase S → all handshakes drop to 0 asynchronously, and `param`=0 afterwards. A following decaps restarts at phase 0.
